// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared instruction and state types for the K&S processor
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_LOAD_IR = 4'd1,
        S_DECODE  = 4'd2,
        S_LOAD_1  = 4'd3,
        S_LOAD_2  = 4'd4,
        S_STORE_1 = 4'd5,
        S_MOVE    = 4'd6,
        S_ALU     = 4'd7,
        S_BRANCH  = 4'd8,
        S_HALT    = 4'd9
    } state_type;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control strobes and flag/decode inputs between control unit and data path
interface control_unit_if;
    import k_and_s_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle Moore sequencer for the K&S processor
module control_unit
    import k_and_s_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);

    state_type  state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       unused_signed_ovf;

    assign unused_signed_ovf = bus.signed_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:   state_d = S_LOAD_IR;
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                // ALU op is captured here so the ALU state never looks at the live decode
                case (bus.decoded_instruction)
                    I_LOAD:   state_d = S_LOAD_1;
                    I_STORE:  state_d = S_STORE_1;
                    I_MOVE:   state_d = S_MOVE;
                    I_ADD:    begin state_d = S_ALU; op_d = 2'b00; end
                    I_SUB:    begin state_d = S_ALU; op_d = 2'b01; end
                    I_AND:    begin state_d = S_ALU; op_d = 2'b10; end
                    I_OR:     begin state_d = S_ALU; op_d = 2'b11; end
                    I_BRANCH: state_d = S_BRANCH;
                    I_BZERO:  state_d = bus.zero_op            ? S_BRANCH : S_FETCH;
                    I_BNZERO: state_d = !bus.zero_op           ? S_BRANCH : S_FETCH;
                    I_BNEG:   state_d = bus.neg_op             ? S_BRANCH : S_FETCH;
                    I_BNNEG:  state_d = !bus.neg_op            ? S_BRANCH : S_FETCH;
                    I_BOV:    state_d = bus.unsigned_overflow  ? S_BRANCH : S_FETCH;
                    I_BNOV:   state_d = !bus.unsigned_overflow ? S_BRANCH : S_FETCH;
                    I_HALT:   state_d = S_HALT;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_LOAD_1:  state_d = S_LOAD_2;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.addr_sel         = 1'b0;
        bus.c_sel            = 1'b0;
        bus.operation        = 2'b00;
        bus.write_reg_enable = 1'b0;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.halt             = 1'b0;
        case (state_q)
            S_LOAD_IR: begin
                bus.ir_enable = 1'b1;
                bus.pc_enable = 1'b1;
            end
            S_DECODE:  bus.addr_sel = 1'b1;
            S_LOAD_1:  bus.addr_sel = 1'b1;
            S_LOAD_2: begin
                bus.addr_sel         = 1'b1;
                bus.write_reg_enable = 1'b1;
            end
            S_STORE_1: begin
                bus.addr_sel         = 1'b1;
                bus.ram_write_enable = 1'b1;
            end
            S_MOVE: begin
                bus.operation        = 2'b11;
                bus.c_sel            = 1'b1;
                bus.write_reg_enable = 1'b1;
            end
            S_ALU: begin
                bus.operation        = op_q;
                bus.c_sel            = 1'b1;
                bus.write_reg_enable = 1'b1;
                bus.flags_reg_enable = 1'b1;
            end
            S_BRANCH: begin
                bus.branch    = 1'b1;
                bus.pc_enable = 1'b1;
            end
            S_HALT:    bus.halt = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;
    import k_and_s_pkg::*;

    // output vector bits: branch pc ir addr c_sel op[1:0] wre fre rwe halt
    localparam logic [10:0] V_FETCH = 11'h000;
    localparam logic [10:0] V_LDIR  = 11'h300;
    localparam logic [10:0] V_DEC   = 11'h080;
    localparam logic [10:0] V_LD1   = 11'h080;
    localparam logic [10:0] V_LD2   = 11'h088;
    localparam logic [10:0] V_ST1   = 11'h082;
    localparam logic [10:0] V_MOVE  = 11'h078;
    localparam logic [10:0] V_ADD   = 11'h04C;
    localparam logic [10:0] V_SUB   = 11'h05C;
    localparam logic [10:0] V_AND   = 11'h06C;
    localparam logic [10:0] V_OR    = 11'h07C;
    localparam logic [10:0] V_BR    = 11'h600;
    localparam logic [10:0] V_HALT  = 11'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_unit_if cu_if();

    control_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (cu_if)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {cu_if.branch, cu_if.pc_enable, cu_if.ir_enable, cu_if.addr_sel, cu_if.c_sel,
                cu_if.operation, cu_if.write_reg_enable, cu_if.flags_reg_enable,
                cu_if.ram_write_enable, cu_if.halt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cu_if.decoded_instruction = I_NOP;
        cu_if.zero_op = 1'b0;
        cu_if.neg_op = 1'b0;
        cu_if.unsigned_overflow = 1'b0;
        cu_if.signed_overflow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs() !== V_FETCH) begin
                errors++;
                $display("FAIL reset c%0d got %h exp %h", i, outs(), V_FETCH);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_nop_stream();
        logic [10:0] exp [3] = '{V_FETCH, V_LDIR, V_DEC};
        cu_if.decoded_instruction = I_NOP;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (outs() !== exp[i]) begin
                    errors++;
                    $display("FAIL nop n%0d c%0d got %h exp %h", n, i, outs(), exp[i]);
                end
                step();
            end
        end
    endtask

    task automatic test_add_bzero();
        logic [10:0] exp [8] = '{V_FETCH, V_LDIR, V_DEC, V_ADD, V_FETCH, V_LDIR, V_DEC, V_BR};
        cu_if.decoded_instruction = I_ADD;
        cu_if.zero_op = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                cu_if.decoded_instruction = I_BZERO;
                cu_if.zero_op = 1'b1;
            end
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL add_bzero c%0d got %h exp %h", i, outs(), exp[i]);
            end
            step();
        end
    endtask

    task automatic test_bnzero_not_taken();
        logic [10:0] exp [4] = '{V_FETCH, V_LDIR, V_DEC, V_FETCH};
        cu_if.decoded_instruction = I_BNZERO;
        cu_if.zero_op = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL bnzero c%0d got %h exp %h", i, outs(), exp[i]);
            end
            if (i < 3) step();
        end
    endtask

    // remaining conditional branches: {instr, zero, neg, ovf, taken}
    task automatic test_branches();
        decoded_instruction_type ins [6] = '{I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_BZERO, I_BRANCH};
        logic [2:0] flg [6] = '{3'b010, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        logic       tkn [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [10:0] expv;
        for (int k = 0; k < 6; k++) begin
            cu_if.decoded_instruction = ins[k];
            {cu_if.zero_op, cu_if.neg_op, cu_if.unsigned_overflow} = flg[k];
            step();
            step();
            step();
            expv = tkn[k] ? V_BR : V_FETCH;
            checks++;
            if (outs() !== expv) begin
                errors++;
                $display("FAIL branch k%0d got %h exp %h", k, outs(), expv);
            end
            if (tkn[k]) step();
        end
        cu_if.zero_op = 1'b0;
        cu_if.neg_op = 1'b0;
        cu_if.unsigned_overflow = 1'b0;
    endtask

    task automatic test_load_store();
        logic [10:0] exp [9] = '{V_FETCH, V_LDIR, V_DEC, V_LD1, V_LD2,
                                 V_FETCH, V_LDIR, V_DEC, V_ST1};
        cu_if.decoded_instruction = I_LOAD;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) cu_if.decoded_instruction = I_STORE;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL load_store c%0d got %h exp %h", i, outs(), exp[i]);
            end
            step();
        end
        checks++;
        if (outs() !== V_FETCH) begin
            errors++;
            $display("FAIL store_return got %h exp %h", outs(), V_FETCH);
        end
    endtask

    task automatic test_move_alu_ops();
        decoded_instruction_type ins [4] = '{I_MOVE, I_SUB, I_OR, I_AND};
        logic [10:0] expv [4] = '{V_MOVE, V_SUB, V_OR, V_AND};
        for (int k = 0; k < 4; k++) begin
            cu_if.decoded_instruction = ins[k];
            step();
            step();
            step();
            checks++;
            if (outs() !== expv[k]) begin
                errors++;
                $display("FAIL op k%0d got %h exp %h", k, outs(), expv[k]);
            end
            step();
        end
    endtask

    task automatic test_op_registered();
        cu_if.decoded_instruction = I_SUB;
        step();
        step();
        step();
        cu_if.decoded_instruction = I_OR;
        #1;
        checks++;
        if (outs() !== V_SUB) begin
            errors++;
            $display("FAIL op_registered got %h exp %h", outs(), V_SUB);
        end
        cu_if.decoded_instruction = I_NOP;
        step();
    endtask

    task automatic test_halt_and_reset();
        int bad = 0;
        cu_if.decoded_instruction = I_HALT;
        step();
        step();
        step();
        for (int i = 0; i < 50; i++) begin
            if (outs() !== V_HALT) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold got %0d bad cycles exp 0", bad);
        end
        rst = 1'b1;
        step();
        checks++;
        if (outs() !== V_FETCH) begin
            errors++;
            $display("FAIL halt_reset got %h exp %h", outs(), V_FETCH);
        end
        rst = 1'b0;
        cu_if.decoded_instruction = I_LOAD;
        step();
        step();
        step();
        checks++;
        if (outs() !== V_LD1) begin
            errors++;
            $display("FAIL reach_load1 got %h exp %h", outs(), V_LD1);
        end
        rst = 1'b1;
        step();
        checks++;
        if (outs() !== V_FETCH) begin
            errors++;
            $display("FAIL mid_load_reset got %h exp %h", outs(), V_FETCH);
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== V_LDIR) begin
            errors++;
            $display("FAIL restart got %h exp %h", outs(), V_LDIR);
        end
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_add_bzero();
        test_bnzero_not_taken();
        test_branches();
        test_load_store();
        test_move_alu_ops();
        test_op_registered();
        test_halt_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
